// File: rtl/m1resetctl.sv
// m1resetctl: reset request controller merging button, software, watchdog and debug requests
module m1resetctl #(
  parameter logic [3:0]  csr_addr        = 4'h0,
  parameter logic [19:0] debounce_cycles = 20'd500000,
  parameter logic [7:0]  holdoff_cycles  = 8'd16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  input  logic        btn_rst_n,
  input  logic        dbg_rst,
  output logic        trigger_reset,
  output logic        wdt_irq
);
  typedef enum logic [1:0] {IDLE, FIRE, HOLD} state_t;
  localparam logic [31:0] swrst_key = 32'h52535421;
  state_t state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic btn_s1_q, btn_s2_q, deb_q, deb_d, deb_flip;
  logic [19:0] deb_cnt_q, deb_cnt_d;
  logic sw_req_q, sw_req_d, dbg_q;
  logic en_q, en_d;
  logic [31:0] period_q, period_d, count_q, count_d, csr_do_q, csr_do_d, rd_data;
  // cause survives sys_rst, so its only initial value is the power-up one
  logic [4:0] cause_q = 5'b10000;
  logic [4:0] cause_d;
  logic sel, wr, kick, btn_req, wdt_req, latch, unused_ok;
  logic [3:0] req;
  assign sel = csr_a[13:10] == csr_addr;
  assign wr = sel && csr_we;
  assign kick = wr && csr_a[2:0] == 3'd2 && csr_di[1];
  assign unused_ok = ^csr_a[9:3];
  assign req = {dbg_q, wdt_req, sw_req_q, btn_req};
  assign trigger_reset = state_q == FIRE;
  assign wdt_irq = en_q && count_q < (period_q >> 1);
  assign csr_do = csr_do_q;
  // debounce: the level flips after debounce_cycles consecutive differing samples
  always_comb begin
    deb_flip = btn_s2_q != deb_q && deb_cnt_q == debounce_cycles - 20'd1;
    deb_d = deb_flip ? btn_s2_q : deb_q;
    deb_cnt_d = (btn_s2_q == deb_q || deb_flip) ? 20'd0 : deb_cnt_q + 20'd1;
    btn_req = deb_q && !deb_d;
  end
  // watchdog: set-only enable, kick or timeout reloads, kick beats timeout
  always_comb begin
    sw_req_d = wr && csr_a[2:0] == 3'd0 && csr_di == swrst_key;
    en_d = en_q || (wr && csr_a[2:0] == 3'd2 && csr_di[0]);
    period_d = (wr && csr_a[2:0] == 3'd1) ? csr_di : period_q;
    count_d = en_q ? ((kick || count_q == 32'd0) ? period_q : count_q - 32'd1) : en_d ? period_q : count_q;
    wdt_req = en_q && count_q == 32'd0 && !kick;
  end
  // request fsm: fire once, then drop requests for the holdoff window
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    latch = 1'b0;
    case (state_q)
      IDLE: begin
        latch = |req;
        state_d = latch ? FIRE : IDLE;
      end
      FIRE: begin
        state_d = HOLD;
        hold_d = holdoff_cycles;
      end
      default: begin
        hold_d = hold_q - 8'd1;
        state_d = hold_q <= 8'd1 ? IDLE : HOLD;
      end
    endcase
  end
  // csr read mux and cause update, where a new cause bit beats a simultaneous clear
  always_comb begin
    rd_data = csr_a[2:0] == 3'd1 ? period_q :
              csr_a[2:0] == 3'd2 ? {31'd0, en_q} :
              csr_a[2:0] == 3'd3 ? count_q :
              csr_a[2:0] == 3'd4 ? {27'd0, cause_q} : 32'd0;
    csr_do_d = sel ? rd_data : 32'd0;
    cause_d = (cause_q & ~((wr && csr_a[2:0] == 3'd4) ? csr_di[4:0] : 5'd0)) |
              ((latch && !sys_rst) ? {1'b0, req} : 5'd0);
  end
  // state registers cleared by sys_rst
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      hold_q <= 8'd0;
      btn_s1_q <= 1'b1;
      btn_s2_q <= 1'b1;
      deb_q <= 1'b1;
      deb_cnt_q <= 20'd0;
      sw_req_q <= 1'b0;
      dbg_q <= 1'b0;
      en_q <= 1'b0;
      period_q <= 32'd0;
      count_q <= 32'd0;
      csr_do_q <= 32'd0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      btn_s1_q <= btn_rst_n;
      btn_s2_q <= btn_s1_q;
      deb_q <= deb_d;
      deb_cnt_q <= deb_cnt_d;
      sw_req_q <= sw_req_d;
      dbg_q <= dbg_rst;
      en_q <= en_d;
      period_q <= period_d;
      count_q <= count_d;
      csr_do_q <= csr_do_d;
    end
  end
  // reset cause register, deliberately outside the sys_rst domain
  always_ff @(posedge sys_clk) begin
    cause_q <= cause_d;
  end
endmodule
